// File: rtl/mc_ctrl_fsm_if.sv
// Control bus between the multi-cycle main controller and the IR/IFU/GRF/ALU/DM datapath.
// MC_MEM_WAIT_EN adds the dm_ready return signal from data memory.
interface mc_ctrl_fsm_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
`ifdef MC_MEM_WAIT_EN
  logic             dm_ready;
`endif
  logic             ir_we;
  logic             pc_we;
  logic             PCSrc;
  logic             Jump;
  logic             jr;
  logic             reg_we;
  logic [1:0]       reg_dst;
  logic [1:0]       mem_to_reg;
  logic             alu_src;
  logic [1:0]       ext_op;
  logic [2:0]       alu_op;
  logic             mem_we;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  // Controller side.
  modport master (
`ifdef MC_MEM_WAIT_EN
    input  dm_ready,
`endif
    input  opcode, funct, zero,
    output ir_we, pc_we, PCSrc, Jump, jr, reg_we, reg_dst, mem_to_reg,
    output alu_src, ext_op, alu_op, mem_we, state, instr_cnt
  );

  // Datapath side.
  modport slave (
`ifdef MC_MEM_WAIT_EN
    output dm_ready,
`endif
    output opcode, funct, zero,
    input  ir_we, pc_we, PCSrc, Jump, jr, reg_we, reg_dst, mem_to_reg,
    input  alu_src, ext_op, alu_op, mem_we, state, instr_cnt
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencing, decode and retire counter.
// Optional MC_MEM_WAIT_EN: MEM is held until data memory returns dm_ready.
module mc_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  mc_ctrl_fsm_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd2;
  localparam logic [2:0] ALU_PASSB = 3'd3;
  localparam logic [1:0] EXT_ZERO  = 2'd0;
  localparam logic [1:0] EXT_SIGN  = 2'd1;
  localparam logic [1:0] EXT_LUI   = 2'd2;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic is_r, is_add, is_sub, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_arith, is_imm, is_mem, mem_done;

  logic       ir_we_c, pc_we_c, pcsrc_c, jump_c, jr_c, reg_we_c, mem_we_c, alu_src_c;
  logic [1:0] reg_dst_c, mem_to_reg_c, ext_op_c;
  logic [2:0] alu_op_c;

  assign is_r     = (bus.opcode == OP_RTYPE);
  assign is_add   = is_r && (bus.funct == FN_ADD);
  assign is_sub   = is_r && (bus.funct == FN_SUB);
  assign is_jr    = is_r && (bus.funct == FN_JR);
  assign is_ori   = (bus.opcode == OP_ORI);
  assign is_lui   = (bus.opcode == OP_LUI);
  assign is_lw    = (bus.opcode == OP_LW);
  assign is_sw    = (bus.opcode == OP_SW);
  assign is_beq   = (bus.opcode == OP_BEQ);
  assign is_j     = (bus.opcode == OP_J);
  assign is_jal   = (bus.opcode == OP_JAL);
  assign is_arith = is_add || is_sub;
  assign is_imm   = is_ori || is_lui;
  assign is_mem   = is_lw || is_sw;

  // Memory handshake: the controller presents the access in MEM (mem_we for sw) and keeps
  // presenting it every cycle until dm_ready=1; MEM is left on the edge where dm_ready=1.
`ifdef MC_MEM_WAIT_EN
  assign mem_done = bus.dm_ready;
`else
  assign mem_done = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pc_we_c) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_we_c      = 1'b0;
    pc_we_c      = 1'b0;
    pcsrc_c      = 1'b0;
    jump_c       = 1'b0;
    jr_c         = 1'b0;
    reg_we_c     = 1'b0;
    mem_we_c     = 1'b0;
    reg_dst_c    = 2'd0;
    mem_to_reg_c = 2'd0;
    alu_src_c    = 1'b0;
    ext_op_c     = EXT_ZERO;
    alu_op_c     = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_we_c = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // j/jal/jr and every unrecognised encoding retire here.
        if (is_arith || is_imm || is_mem || is_beq) begin
          state_d = S_EXEC;
        end else begin
          pc_we_c = 1'b1;
          jump_c  = is_j || is_jal;
          jr_c    = is_jr;
          if (is_jal) begin
            reg_we_c     = 1'b1;
            reg_dst_c    = 2'd2;
            mem_to_reg_c = 2'd2;
          end
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_arith) begin
          alu_op_c = is_sub ? ALU_SUB : ALU_ADD;
        end else if (is_ori) begin
          alu_op_c  = ALU_OR;
          alu_src_c = 1'b1;
          ext_op_c  = EXT_ZERO;
        end else if (is_lui) begin
          alu_op_c  = ALU_PASSB;
          alu_src_c = 1'b1;
          ext_op_c  = EXT_LUI;
        end else if (is_mem) begin
          alu_op_c  = ALU_ADD;
          alu_src_c = 1'b1;
          ext_op_c  = EXT_SIGN;
        end else if (is_beq) begin
          alu_op_c = ALU_SUB;
        end
        if (is_mem) begin
          state_d = S_MEM;
        end else if (is_arith || is_imm) begin
          state_d = S_WB;
        end else begin
          pc_we_c = 1'b1;
          pcsrc_c = is_beq && bus.zero;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        mem_we_c = is_sw;
        if (mem_done) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            pc_we_c = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_we_c     = 1'b1;
        pc_we_c      = 1'b1;
        reg_dst_c    = is_arith ? 2'd1 : 2'd0;
        mem_to_reg_c = is_lw ? 2'd1 : 2'd0;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write enables are suppressed while reset is held so an abandoned instruction commits nothing.
  assign bus.ir_we      = ir_we_c  && !reset;
  assign bus.pc_we      = pc_we_c  && !reset;
  assign bus.reg_we     = reg_we_c && !reset;
  assign bus.mem_we     = mem_we_c && !reset;
  assign bus.PCSrc      = pcsrc_c;
  assign bus.Jump       = jump_c;
  assign bus.jr         = jr_c;
  assign bus.reg_dst    = reg_dst_c;
  assign bus.mem_to_reg = mem_to_reg_c;
  assign bus.alu_src    = alu_src_c;
  assign bus.ext_op     = ext_op_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.state      = state_q;
  assign bus.instr_cnt  = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle vector table plus reset and memory-wait sequences.
// Build with +define+MC_MEM_WAIT_EN to include the dm_ready hold sequence.
module tb_mc_ctrl_fsm;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc_ctrl_fsm_if #(.CNT_W(CNT_W)) bus ();
  mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic rdy_drv = 1'b1;
`ifdef MC_MEM_WAIT_EN
  assign bus.dm_ready = rdy_drv;
`endif

  // {ir_we, pc_we, PCSrc, Jump, jr, reg_we, reg_dst, mem_to_reg, alu_src, ext_op, alu_op, mem_we}
  logic [16:0] act_ctl;
  logic [3:0]  act_we;
  assign act_ctl = {bus.ir_we, bus.pc_we, bus.PCSrc, bus.Jump, bus.jr, bus.reg_we, bus.reg_dst,
                    bus.mem_to_reg, bus.alu_src, bus.ext_op, bus.alu_op, bus.mem_we};
  assign act_we  = {bus.ir_we, bus.pc_we, bus.reg_we, bus.mem_we};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [2:0]  st;
    logic [16:0] ctl;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  function automatic logic [16:0] c(input logic ir, input logic pc, input logic psrc,
                                    input logic jmp, input logic jrr, input logic rw,
                                    input logic [1:0] rd, input logic [1:0] m2r, input logic as,
                                    input logic [1:0] ext, input logic [2:0] alu, input logic mw);
    return {ir, pc, psrc, jmp, jrr, rw, rd, m2r, as, ext, alu, mw};
  endfunction

  task automatic row(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic [2:0] st, input logic [16:0] ctl);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.st = st; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z);
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
  endtask

  logic [16:0] kf, kn, k_wb_r, k_wb_i, k_dec_pc;

  initial begin
    kf       = c(1,0,0,0,0,0,2'd0,2'd0,0,2'd0,3'd0,0);
    kn       = c(0,0,0,0,0,0,2'd0,2'd0,0,2'd0,3'd0,0);
    k_wb_r   = c(0,1,0,0,0,1,2'd1,2'd0,0,2'd0,3'd0,0);
    k_wb_i   = c(0,1,0,0,0,1,2'd0,2'd0,0,2'd0,3'd0,0);
    k_dec_pc = c(0,1,0,0,0,0,2'd0,2'd0,0,2'd0,3'd0,0);

    // add (zero=1 must not leak into PCSrc)
    row(6'h00, 6'h20, 1, 3'd0, kf); row(6'h00, 6'h20, 1, 3'd1, kn);
    row(6'h00, 6'h20, 1, 3'd2, kn); row(6'h00, 6'h20, 1, 3'd4, k_wb_r);
    // sub
    row(6'h00, 6'h22, 0, 3'd0, kf); row(6'h00, 6'h22, 0, 3'd1, kn);
    row(6'h00, 6'h22, 0, 3'd2, c(0,0,0,0,0,0,2'd0,2'd0,0,2'd0,3'd1,0));
    row(6'h00, 6'h22, 0, 3'd4, k_wb_r);
    // ori
    row(6'h0D, 6'h00, 0, 3'd0, kf); row(6'h0D, 6'h00, 0, 3'd1, kn);
    row(6'h0D, 6'h00, 0, 3'd2, c(0,0,0,0,0,0,2'd0,2'd0,1,2'd0,3'd2,0));
    row(6'h0D, 6'h00, 0, 3'd4, k_wb_i);
    // lui
    row(6'h0F, 6'h00, 0, 3'd0, kf); row(6'h0F, 6'h00, 0, 3'd1, kn);
    row(6'h0F, 6'h00, 0, 3'd2, c(0,0,0,0,0,0,2'd0,2'd0,1,2'd2,3'd3,0));
    row(6'h0F, 6'h00, 0, 3'd4, k_wb_i);
    // lw: 5 cycles
    row(6'h23, 6'h00, 0, 3'd0, kf); row(6'h23, 6'h00, 0, 3'd1, kn);
    row(6'h23, 6'h00, 0, 3'd2, c(0,0,0,0,0,0,2'd0,2'd0,1,2'd1,3'd0,0));
    row(6'h23, 6'h00, 0, 3'd3, kn);
    row(6'h23, 6'h00, 0, 3'd4, c(0,1,0,0,0,1,2'd0,2'd1,0,2'd0,3'd0,0));
    // sw: 4 cycles, mem_we in MEM only
    row(6'h2B, 6'h00, 0, 3'd0, kf); row(6'h2B, 6'h00, 0, 3'd1, kn);
    row(6'h2B, 6'h00, 0, 3'd2, c(0,0,0,0,0,0,2'd0,2'd0,1,2'd1,3'd0,0));
    row(6'h2B, 6'h00, 0, 3'd3, c(0,1,0,0,0,0,2'd0,2'd0,0,2'd0,3'd0,1));
    // beq taken / not taken
    row(6'h04, 6'h00, 1, 3'd0, kf); row(6'h04, 6'h00, 1, 3'd1, kn);
    row(6'h04, 6'h00, 1, 3'd2, c(0,1,1,0,0,0,2'd0,2'd0,0,2'd0,3'd1,0));
    row(6'h04, 6'h00, 0, 3'd0, kf); row(6'h04, 6'h00, 0, 3'd1, kn);
    row(6'h04, 6'h00, 0, 3'd2, c(0,1,0,0,0,0,2'd0,2'd0,0,2'd0,3'd1,0));
    // j, jal, jr, nop, unknown opcode, unknown funct
    row(6'h02, 6'h00, 1, 3'd0, kf); row(6'h02, 6'h00, 1, 3'd1, c(0,1,0,1,0,0,2'd0,2'd0,0,2'd0,3'd0,0));
    row(6'h03, 6'h00, 0, 3'd0, kf); row(6'h03, 6'h00, 0, 3'd1, c(0,1,0,1,0,1,2'd2,2'd2,0,2'd0,3'd0,0));
    row(6'h00, 6'h08, 0, 3'd0, kf); row(6'h00, 6'h08, 0, 3'd1, c(0,1,0,0,1,0,2'd0,2'd0,0,2'd0,3'd0,0));
    row(6'h00, 6'h00, 0, 3'd0, kf); row(6'h00, 6'h00, 0, 3'd1, k_dec_pc);
    row(6'h3F, 6'h00, 0, 3'd0, kf); row(6'h3F, 6'h00, 0, 3'd1, k_dec_pc);
    row(6'h00, 6'h2A, 0, 3'd0, kf); row(6'h00, 6'h2A, 0, 3'd1, k_dec_pc);
    // four more jumps push the 4-bit retire counter past 15 so it wraps
    for (int i = 0; i < 4; i++) begin
      row(6'h02, 6'h00, 0, 3'd0, kf); row(6'h02, 6'h00, 0, 3'd1, c(0,1,0,1,0,0,2'd0,2'd0,0,2'd0,3'd0,0));
    end

    // reset held two cycles, write enables forced low even with jal/FETCH decode
    drive(6'h03, 6'h00, 0);
    reset = 1'b1;
    @(negedge clk); #1 chk("we_in_reset0", {28'd0, act_we}, 32'd0);
    @(negedge clk); #1 chk("we_in_reset1", {28'd0, act_we}, 32'd0);
    chk("state_in_reset", {29'd0, bus.state}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("state_after_reset", {29'd0, bus.state}, 32'd0);
    chk("cnt_after_reset", {28'd0, bus.instr_cnt}, 32'd0);

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].op, vecs[i].fn, vecs[i].z);
      #1;
      chk($sformatf("state[%0d]", i), {29'd0, bus.state}, {29'd0, vecs[i].st});
      chk($sformatf("ctl[%0d]", i), {15'd0, act_ctl}, {15'd0, vecs[i].ctl});
      chk($sformatf("cnt[%0d]", i), {28'd0, bus.instr_cnt}, {28'd0, exp_cnt});
      @(posedge clk);
      if (vecs[i].ctl[15]) exp_cnt = exp_cnt + 1'b1;
    end
    @(negedge clk); #1;
    chk("cnt_wrapped", {28'd0, bus.instr_cnt}, 32'd2);
    chk("state_end_table", {29'd0, bus.state}, 32'd0);

    // reset during EXEC of lw: nothing commits, FETCH follows, counter cleared
    drive(6'h23, 6'h00, 0);
    @(negedge clk); @(negedge clk); #1;
    chk("lw_in_exec", {29'd0, bus.state}, 32'd2);
    reset = 1'b1;
    #1 chk("we_reset_exec", {28'd0, act_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("state_after_mid_reset", {29'd0, bus.state}, 32'd0);
    chk("cnt_after_mid_reset", {28'd0, bus.instr_cnt}, 32'd0);
    chk("ir_we_after_mid_reset", {31'd0, bus.ir_we}, 32'd1);
    drive(6'h00, 6'h20, 0);
    repeat (4) @(negedge clk);
    #1;
    chk("cnt_after_add", {28'd0, bus.instr_cnt}, 32'd1);
    chk("state_after_add", {29'd0, bus.state}, 32'd0);

`ifdef MC_MEM_WAIT_EN
    // sw with dm_ready low three cycles: MEM held four cycles, pc_we only on the last
    drive(6'h2B, 6'h00, 0);
    rdy_drv = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      rdy_drv = (k == 3);
      #1;
      chk($sformatf("wait_state[%0d]", k), {29'd0, bus.state}, 32'd3);
      chk($sformatf("wait_mem_we[%0d]", k), {31'd0, bus.mem_we}, 32'd1);
      chk($sformatf("wait_pc_we[%0d]", k), {31'd0, bus.pc_we}, (k == 3) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    #1;
    chk("wait_state_after", {29'd0, bus.state}, 32'd0);
    chk("wait_cnt_after", {28'd0, bus.instr_cnt}, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
